unidade_controle_mc: RTL

- Multicycle main control FSM. It drives the ALU's 4-bit ULAop and the datapath enables for each instruction.
- Sits between the instruction register / memory interface and the datapath, and consumes the ALU zero flag for branches.
- Sequences fetch, decode, execute, memory and write-back. It waits on a memory ready handshake and counts retired instructions.

---
 rtl/unidade_controle_mc_if.sv | 35 +++
 rtl/unidade_controle_mc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_mc_if.sv
// Control bundle between the multicycle main controller and the datapath/memory.
// The controller drives the datapath selects and strobes and reads IR opcode, the ALU zero flag and mem_ready.
// Memory handshake: MemRead/MemWrite together with IorD are held stable until the cycle
// in which mem_ready is 1; that cycle completes the access, and mem_ready is ignored in any other cycle.
interface unidade_controle_mc_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic [3:0]     ULAop;
  logic           ULASrcA;
  logic [1:0]     ULASrcB;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           RegDst;
  logic           MemToReg;
  logic           RegWrite;
  logic           PCWrite;
  logic [1:0]     PCSrc;

  modport master (
    input  opcode, zero, mem_ready,
    output ULAop, ULASrcA, ULASrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemToReg, RegWrite, PCWrite, PCSrc
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ULAop, ULASrcA, ULASrcB, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemToReg, RegWrite, PCWrite, PCSrc
  );
endinterface

// File: rtl/unidade_controle_mc.sv
// Multicycle main control FSM: fetch/decode/execute/memory/write-back sequencing,
// memory ready handshake, sticky illegal-opcode flag and retired-instruction counter.
module unidade_controle_mc #(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  unidade_controle_mc_if.master bus,
  output logic                  halted,
  output logic                  illegal,
  output logic [CNTW-1:0]       instr_count,
  output logic [3:0]            dbg_state
);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_LUI  = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:                              state_d = S_MEM_ADDR;
          OP_R:                                      state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                            state_d = S_BRANCH;
          OP_J:                                      state_d = S_JUMP;
          OP_HALT:                                   state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
    cnt_d = retire ? cnt_q + CNTW'(1) : cnt_q;
  end

  // Outputs are forced to their idle values while reset is held, so an aborted
  // instruction can never write the register file or PC in the reset cycle.
  always_comb begin
    bus.ULAop    = 4'b0000;
    bus.ULASrcA  = 1'b0;
    bus.ULASrcB  = 2'd0;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemToReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSrc    = 2'd0;
    halted       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ULASrcB = 2'd1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE:    bus.ULASrcB = 2'd3;
        S_MEM_ADDR: begin
          bus.ULASrcA = 1'b1;
          bus.ULASrcB = 2'd2;
        end
        S_MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEM_WB: begin
          bus.RegWrite = 1'b1;
          bus.MemToReg = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXEC_R: begin
          bus.ULASrcA = 1'b1;
          bus.ULAop   = 4'b0010;
        end
        S_R_WB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_EXEC_I: begin
          bus.ULASrcA = 1'b1;
          bus.ULASrcB = 2'd2;
          case (bus.opcode)
            OP_ANDI: bus.ULAop = 4'b0011;
            OP_ORI:  bus.ULAop = 4'b0100;
            OP_SLTI: bus.ULAop = 4'b0101;
            OP_LUI:  bus.ULAop = 4'b0110;
            default: bus.ULAop = 4'b0000;
          endcase
        end
        S_I_WB:      bus.RegWrite = 1'b1;
        S_BRANCH: begin
          bus.ULASrcA = 1'b1;
          bus.ULAop   = 4'b0001;
          bus.PCSrc   = 2'd1;
          bus.PCWrite = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                        ((bus.opcode == OP_BNE) && !bus.zero);
        end
        S_JUMP: begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = 2'd2;
        end
        S_HALT:      halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;
  assign dbg_state   = state_q;

endmodule
